// File: rtl/tlc_pkg.sv
// tlc_pkg: shared debounce state type and default conditioning constants
package tlc_pkg;
    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} deb_state_t;
    localparam int TLC_SYNC_STAGES     = 2;
    localparam int TLC_DEBOUNCE_CYCLES = 16;
endpackage

// File: rtl/tlc_debounce_ch.sv
// tlc_debounce_ch: pad synchronizer plus debounce FSM with optional fail-safe fast assert
module tlc_debounce_ch
    import tlc_pkg::*;
#(
    parameter int SYNC_STAGES     = TLC_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = TLC_DEBOUNCE_CYCLES,
    parameter bit FAST_ASSERT     = 1'b0,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pad,
    output logic o_level,
    output logic o_toggle
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    deb_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_toggle;
    logic                   w_s;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign o_level  = r_level;
    assign o_toggle = r_toggle;

    // Shift the raw pad through the synchronizer chain, preset to the channel's idle level
    always_ff @(posedge clk) begin
        if (rst) r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
    end

    // Commit a new level only after DEBOUNCE_CYCLES consecutive agreeing samples; fast channels assert at once
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
            r_level  <= RESET_LEVEL;
            r_cnt    <= '0;
            r_toggle <= 1'b0;
        end else begin
            r_toggle <= 1'b0;
            if (FAST_ASSERT && w_s && !r_level) begin
                r_state  <= STABLE_HI;
                r_level  <= 1'b1;
                r_toggle <= 1'b1;
                r_cnt    <= '0;
            end else begin
                case (r_state)
                    STABLE_LO: if (w_s) begin
                        r_state <= WAIT_HI;
                        r_cnt   <= CNT_W'(1);
                    end
                    WAIT_HI: if (!w_s) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state  <= STABLE_HI;
                        r_level  <= 1'b1;
                        r_toggle <= 1'b1;
                        r_cnt    <= '0;
                    end else r_cnt <= r_cnt + CNT_W'(1);
                    STABLE_HI: if (!w_s) begin
                        r_state <= WAIT_LO;
                        r_cnt   <= CNT_W'(1);
                    end
                    WAIT_LO: if (w_s) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state  <= STABLE_LO;
                        r_level  <= 1'b0;
                        r_toggle <= 1'b1;
                        r_cnt    <= '0;
                    end else r_cnt <= r_cnt + CNT_W'(1);
                    default: r_state <= r_state;
                endcase
            end
        end
    end
endmodule

// File: rtl/tlc_pad_conditioner.sv
// tlc_pad_conditioner: conditions FM/TEST/CLR pads and masks mode toggles while CLR is held
module tlc_pad_conditioner
    import tlc_pkg::*;
#(
    parameter int SYNC_STAGES     = TLC_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = TLC_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic fm_pad,
    input  logic test_pad,
    input  logic clr_pad,
    output logic fm_level,
    output logic test_level,
    output logic clr_level,
    output logic fm_toggle,
    output logic test_toggle,
    output logic clr_rise
);
    logic w_fm_tog, w_test_tog, w_clr_tog;

    tlc_debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                      .FAST_ASSERT(1'b0), .RESET_LEVEL(1'b0)) u_fm (
        .clk(clk), .rst(rst), .i_pad(fm_pad), .o_level(fm_level), .o_toggle(w_fm_tog));

    tlc_debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                      .FAST_ASSERT(1'b0), .RESET_LEVEL(1'b0)) u_test (
        .clk(clk), .rst(rst), .i_pad(test_pad), .o_level(test_level), .o_toggle(w_test_tog));

    tlc_debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                      .FAST_ASSERT(1'b1), .RESET_LEVEL(1'b1)) u_clr (
        .clk(clk), .rst(rst), .i_pad(clr_pad), .o_level(clr_level), .o_toggle(w_clr_tog));

    assign fm_toggle   = w_fm_tog & ~clr_level;
    assign test_toggle = w_test_tog & ~clr_level;
    assign clr_rise    = w_clr_tog & clr_level;
endmodule

// File: tb/tb_tlc_pad_conditioner.sv
// tb_tlc_pad_conditioner: directed test-plan steps plus random pad bouncing against a run-length model
module tb_tlc_pad_conditioner;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fm_pad = 1'b0, test_pad = 1'b0, clr_pad = 1'b0;
    logic fm_level, test_level, clr_level, fm_toggle, test_toggle, clr_rise;

    int checks = 0;
    int errors = 0;

    logic m_sh  [3][SYNC];
    logic m_lvl [3];
    logic m_flip[3];
    int   m_run [3];

    always #5 clk = ~clk;

    tlc_pad_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .fm_pad(fm_pad), .test_pad(test_pad), .clr_pad(clr_pad),
        .fm_level(fm_level), .test_level(test_level), .clr_level(clr_level),
        .fm_toggle(fm_toggle), .test_toggle(test_toggle), .clr_rise(clr_rise));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Each pad is seen SYNC edges late; a level flips once the delayed samples have
    // disagreed with it DEB times in a row, except CLR which rises on its first high sample.
    task automatic model_edge();
        logic p[3];
        logic x;
        p[0] = fm_pad; p[1] = test_pad; p[2] = clr_pad;
        for (int i = 0; i < 3; i++) begin
            m_flip[i] = 1'b0;
            if (rst) begin
                for (int k = 0; k < SYNC; k++) m_sh[i][k] = (i == 2);
                m_lvl[i] = (i == 2);
                m_run[i] = 0;
            end else begin
                x = m_sh[i][SYNC-1];
                for (int k = SYNC - 1; k > 0; k--) m_sh[i][k] = m_sh[i][k-1];
                m_sh[i][0] = p[i];
                if (i == 2 && x && !m_lvl[i]) begin
                    m_lvl[i] = 1'b1; m_flip[i] = 1'b1; m_run[i] = 0;
                end else begin
                    m_run[i] = (x != m_lvl[i]) ? m_run[i] + 1 : 0;
                    if (m_run[i] == DEB) begin
                        m_lvl[i] = ~m_lvl[i]; m_flip[i] = 1'b1; m_run[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("fm_level",    fm_level,    m_lvl[0]);
        chk("test_level",  test_level,  m_lvl[1]);
        chk("clr_level",   clr_level,   m_lvl[2]);
        chk("fm_toggle",   fm_toggle,   m_flip[0] & ~m_lvl[2]);
        chk("test_toggle", test_toggle, m_flip[1] & ~m_lvl[2]);
        chk("clr_rise",    clr_rise,    m_flip[2] & m_lvl[2]);
    endtask

    initial begin
        // reset release with clr_pad low: CLR held for SYNC+DEB edges, no rise
        step(1'b1);
        step(1'b1);
        chk("rst_clr_level", clr_level, 1'b1);
        chk("rst_fm_level", fm_level, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0);
            chk("s1_clr_level", clr_level, logic'(k < 6));
            chk("s1_clr_rise", clr_rise, 1'b0);
        end
        // fm rise with 6-edge latency and one-cycle toggle
        fm_pad = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(1'b0);
            chk("s2_fm_level", fm_level, logic'(k >= 6));
            chk("s2_fm_toggle", fm_toggle, logic'(k == 6));
        end
        // test bounce 1,1,1,0 then held high
        test_pad = 1'b1; step(1'b0); step(1'b0); step(1'b0);
        test_pad = 1'b0; step(1'b0);
        test_pad = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1'b0);
            chk("s3_test_level", test_level, logic'(k == 6));
            chk("s3_test_toggle", test_toggle, logic'(k == 6));
        end
        // single-cycle clr glitch: fast assert, debounced release
        clr_pad = 1'b1; step(1'b0);
        chk("s4_clr_lvl_k1", clr_level, 1'b0);
        clr_pad = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            step(1'b0);
            chk("s4_clr_level", clr_level, logic'(k >= 3 && k < 7));
            chk("s4_clr_rise", clr_rise, logic'(k == 3));
        end
        // fm drops while CLR held: level follows, toggle masked
        clr_pad = 1'b1; step(1'b0); step(1'b0); step(1'b0);
        fm_pad = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1'b0);
            chk("s5_fm_level", fm_level, logic'(k < 6));
            chk("s5_fm_toggle", fm_toggle, 1'b0);
        end
        // release CLR, then reset FM mid-debounce at cnt=2
        clr_pad = 1'b0;
        for (int k = 0; k < 6; k++) step(1'b0);
        chk("s6_clr_low", clr_level, 1'b0);
        fm_pad = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b0);
        step(1'b1);
        chk("s6_rst_fm_level", fm_level, 1'b0);
        chk("s6_rst_fm_toggle", fm_toggle, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0);
            chk("s6_fm_level", fm_level, logic'(k == 6));
        end
        // random bouncing on all pads, occasional reset
        for (int n = 0; n < 1500; n++) begin
            fm_pad   = fm_pad   ^ logic'($urandom_range(0, 4) == 0);
            test_pad = test_pad ^ logic'($urandom_range(0, 3) == 0);
            clr_pad  = clr_pad  ^ logic'($urandom_range(0, 6) == 0);
            step(logic'($urandom_range(0, 199) == 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
